// File: rtl/rs_latch_command_driver.sv
`default_nettype none
// ============================================================================
// Module      : rs_latch_command_driver
// Description : Debounces two push-buttons and drives timed, mutually
//               exclusive active-low notS/notR pulses into an RS latch.
// Revision    : 1.0 - initial release
// ============================================================================

module rs_latch_command_driver_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level, so any glitch back to the old level restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == c_db_last) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign rise_o = level_q & ~level_prev_q;

endmodule

module rs_latch_command_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 3,
    parameter int GAP_CYCLES      = 2,
    parameter int INIT_CLEAR      = 1,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic reset_btn,
    output logic notS,
    output logic notR,
    output logic busy,
    output logic state_q,
    output logic shadow_valid
);

    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last   =
        CNT_W'((GAP_CYCLES == 0) ? 0 : (GAP_CYCLES - 1));

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_INIT       = 3'd1,
        ST_IDLE       = 3'd2,
        ST_PULSE_S    = 3'd3,
        ST_PULSE_R    = 3'd4,
        ST_GAP        = 3'd5
    } state_e;

    state_e           fsm_q;
    logic [CNT_W-1:0] cnt_q;
    logic             notS_q;
    logic             notR_q;
    logic             busy_q;
    logic             shadow_q;
    logic             valid_q;
    logic             set_pend_q;
    logic             rst_pend_q;
    logic             w_set_rise;
    logic             w_rst_rise;

    rs_latch_command_driver_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_set (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (set_btn),
        .rise_o (w_set_rise)
    );

    rs_latch_command_driver_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_rst (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (reset_btn),
        .rise_o (w_rst_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_RESET_HOLD;
            cnt_q      <= '0;
            notS_q     <= 1'b1;
            notR_q     <= 1'b1;
            busy_q     <= 1'b0;
            shadow_q   <= 1'b0;
            valid_q    <= 1'b0;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_RESET_HOLD: begin
                    cnt_q <= '0;
                    if (INIT_CLEAR != 0) begin
                        fsm_q  <= ST_INIT;
                        notR_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else begin
                        fsm_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    cnt_q <= '0;
                    // Reset requests win so the latch is never left set by a tie.
                    if (rst_pend_q) begin
                        fsm_q      <= ST_PULSE_R;
                        notR_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        rst_pend_q <= 1'b0;
                    end else if (set_pend_q) begin
                        fsm_q      <= ST_PULSE_S;
                        notS_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        set_pend_q <= 1'b0;
                    end
                end
                ST_INIT, ST_PULSE_S, ST_PULSE_R: begin
                    if (cnt_q == c_pulse_last) begin
                        cnt_q    <= '0;
                        notS_q   <= 1'b1;
                        notR_q   <= 1'b1;
                        shadow_q <= (fsm_q == ST_PULSE_S);
                        valid_q  <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            fsm_q  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            fsm_q <= ST_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == c_gap_last) begin
                        cnt_q  <= '0;
                        fsm_q  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    fsm_q  <= ST_IDLE;
                    cnt_q  <= '0;
                    notS_q <= 1'b1;
                    notR_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase

            // A fresh event outranks the clear issued by the FSM in the same cycle.
            if (w_set_rise) begin
                set_pend_q <= 1'b1;
            end
            if (w_rst_rise) begin
                rst_pend_q <= 1'b1;
            end
        end
    end

    assign notS         = notS_q;
    assign notR         = notR_q;
    assign busy         = busy_q;
    assign state_q      = shadow_q;
    assign shadow_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rs_latch_command_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_latch_command_driver
// Description : Directed vectors, corner sequences and randomized button
//               traffic checked against a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_latch_command_driver;

    localparam int D    = 4;
    localparam int P    = 3;
    localparam int G    = 2;
    localparam int INIT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, set_btn, reset_btn;
    logic notS, notR, busy, state_q, shadow_valid;
    logic rst0, set0, rb0;
    logic notS0, notR0, busy0, state0, valid0;

    rs_latch_command_driver #(
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G),
        .INIT_CLEAR(INIT), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
        .notS(notS), .notR(notR), .busy(busy), .state_q(state_q),
        .shadow_valid(shadow_valid)
    );

    rs_latch_command_driver #(
        .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G),
        .INIT_CLEAR(0), .CNT_W(16)
    ) u_dut0 (
        .clk(clk), .rst(rst0), .set_btn(set0), .reset_btn(rb0),
        .notS(notS0), .notR(notR0), .busy(busy0), .state_q(state0),
        .shadow_valid(valid0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: histories of raw samples and debounced levels per edge,
    // plus a pulse timeline (start edge and kind) for the output side.
    int t        = 0;
    int last_rst = -1;
    bit raw_s_q[$], raw_r_q[$], lvlh_s[$], lvlh_r[$];
    bit lvl_s, lvl_r, pend_s, pend_r, hold, p_set, m_shadow, m_valid;
    int last_tog_s = -1, last_tog_r = -1;
    int next_free = 0;
    int p_start   = -100000;
    bit m_notS = 1, m_notR = 1, m_busy = 0;

    function automatic bit sync_at(input bit is_set, input int k);
        int j = k - 2;
        if (j < 0 || j <= last_rst) return 1'b0;
        return is_set ? raw_s_q[j] : raw_r_q[j];
    endfunction

    // Level flips when the last D synchronized samples all disagree with it
    // and that window lies wholly after the last flip or reset.
    function automatic bit db_flip(input bit is_set, input bit lvl, input int last_tog);
        int lo = t - D + 1;
        if (lo <= last_tog || lo <= last_rst) return 1'b0;
        for (int k = lo; k <= t; k++) begin
            if (sync_at(is_set, k) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic start_pulse(input bit is_set);
        p_start   = t;
        p_set     = is_set;
        next_free = t + P + G + 1;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit b);
        bit rise_s, rise_r, in_p;
        raw_s_q.push_back(s);
        raw_r_q.push_back(b);
        if (r) begin
            last_rst = t;
            lvl_s = 0; lvl_r = 0; pend_s = 0; pend_r = 0; hold = 1;
            p_start = -100000; m_shadow = 0; m_valid = 0;
        end else begin
            rise_s = (t >= 2) && lvlh_s[t-1] && !lvlh_s[t-2];
            rise_r = (t >= 2) && lvlh_r[t-1] && !lvlh_r[t-2];
            if (db_flip(1'b1, lvl_s, last_tog_s)) begin lvl_s = !lvl_s; last_tog_s = t; end
            if (db_flip(1'b0, lvl_r, last_tog_r)) begin lvl_r = !lvl_r; last_tog_r = t; end
            if (hold) begin
                hold = 0;
                if (INIT != 0) start_pulse(1'b0);
                else next_free = t + 1;
            end else if (t >= next_free) begin
                if (pend_r) begin pend_r = 0; start_pulse(1'b0); end
                else if (pend_s) begin pend_s = 0; start_pulse(1'b1); end
            end
            pend_s = pend_s | rise_s;
            pend_r = pend_r | rise_r;
            if (t == p_start + P) begin m_shadow = p_set; m_valid = 1; end
        end
        lvlh_s.push_back(lvl_s);
        lvlh_r.push_back(lvl_r);
        in_p   = (t >= p_start) && (t < p_start + P);
        m_notS = !(in_p && p_set);
        m_notR = !(in_p && !p_set);
        m_busy = (t >= p_start) && (t < p_start + P + G);
        t++;
    endtask

    int low_run = 0, gap_run = 0;
    bit had_pulse = 0;

    task automatic tick();
        bit r_now;
        r_now = rst;
        @(posedge clk);
        #1;
        model_edge(r_now, set_btn, reset_btn);
        chk("model_notS", notS, m_notS);
        chk("model_notR", notR, m_notR);
        chk("model_busy", busy, m_busy);
        chk("model_state_q", state_q, m_shadow);
        chk("model_valid", shadow_valid, m_valid);
        chk("never_both_low", notS | notR, 1'b1);
        chk("never_both_low_dut0", notS0 | notR0, 1'b1);
        if (r_now) begin
            low_run = 0; gap_run = 0; had_pulse = 0;
        end else if (!notS || !notR) begin
            if (low_run == 0 && had_pulse) begin
                total++;
                if (gap_run < G) begin
                    bad++;
                    $display("FAIL gap_len: got %0d want >=%0d (t=%0t)", gap_run, G, $time);
                end
            end
            low_run++;
        end else if (low_run > 0) begin
            chk_int("pulse_len", low_run, P);
            had_pulse = 1; low_run = 0; gap_run = 1;
        end else begin
            gap_run++;
        end
    endtask

    typedef struct {
        bit r, s, b;
        int n;
        bit eS, eR, eB, eQ, eV;
    } vec_t;

    vec_t vecs[12];
    int   npulse;
    bit   prev;

    initial begin
        rst = 1; set_btn = 0; reset_btn = 0;
        rst0 = 1; set0 = 0; rb0 = 0;

        //         r  s  b   n  nS nR bz Q  V
        vecs[0]  = '{1, 0, 0,  3, 1, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0,  1, 1, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 0,  2, 1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0,  1, 1, 1, 1, 0, 1};
        vecs[4]  = '{0, 0, 0,  1, 1, 1, 1, 0, 1};
        vecs[5]  = '{0, 0, 0,  1, 1, 1, 0, 0, 1};
        vecs[6]  = '{0, 1, 0,  7, 1, 1, 0, 0, 1};
        vecs[7]  = '{0, 1, 0,  1, 0, 1, 1, 0, 1};
        vecs[8]  = '{0, 1, 0,  2, 0, 1, 1, 0, 1};
        vecs[9]  = '{0, 1, 0,  1, 1, 1, 1, 1, 1};
        vecs[10] = '{0, 1, 0,  9, 1, 1, 0, 1, 1};
        vecs[11] = '{0, 0, 0, 10, 1, 1, 0, 1, 1};

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].r; set_btn = vecs[i].s; reset_btn = vecs[i].b;
            repeat (vecs[i].n) tick();
            chk($sformatf("vec%0d_notS", i), notS, vecs[i].eS);
            chk($sformatf("vec%0d_notR", i), notR, vecs[i].eR);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].eB);
            chk($sformatf("vec%0d_state_q", i), state_q, vecs[i].eQ);
            chk($sformatf("vec%0d_valid", i), shadow_valid, vecs[i].eV);
        end

        // Bouncing set button never survives the debouncer.
        for (int i = 0; i < 10; i++) begin
            set_btn = (i % 2 == 0);
            tick();
            chk("bounce_busy", busy, 1'b0);
            chk("bounce_notS", notS, 1'b1);
        end
        set_btn = 0;
        repeat (12) begin
            tick();
            chk("bounce_settle_notS", notS, 1'b1);
        end

        // Simultaneous press: reset pulse, gap, then set pulse.
        set_btn = 1; reset_btn = 1;
        repeat (8) tick();
        set_btn = 0; reset_btn = 0;
        repeat (20) tick();
        chk("simul_state_q", state_q, 1'b1);
        chk("simul_busy", busy, 1'b0);

        // Set pressed during a reset pulse and again before the gap ends.
        reset_btn = 1;
        for (int i = 0; i < 20 && notR !== 1'b0; i++) tick();
        chk("rpulse_seen", notR, 1'b0);
        reset_btn = 0;
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            set_btn = (i < 2) || (i >= 3 && i < 8);
            prev = notS;
            tick();
            if (prev && !notS) npulse++;
        end
        set_btn = 0;
        chk_int("gap_press_pulses", npulse, 1);
        chk("gap_press_state_q", state_q, 1'b1);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 0;
            end else begin
                set_btn   = 1'($urandom_range(0, 1));
                reset_btn = ($urandom_range(0, 2) == 0);
                repeat ($urandom_range(1, 10)) tick();
            end
        end
        set_btn = 0; reset_btn = 0;
        repeat (30) tick();

        // Reset on the second cycle of a set pulse (no power-up clear build).
        rst0 = 0;
        repeat (3) tick();
        set0 = 1;
        for (int i = 0; i < 20 && notS0 !== 1'b0; i++) tick();
        chk("dut0_pulse_seen", notS0, 1'b0);
        tick();
        chk("dut0_pulse_2nd", notS0, 1'b0);
        rst0 = 1; set0 = 0;
        tick();
        chk("dut0_abort_notS", notS0, 1'b1);
        chk("dut0_abort_notR", notR0, 1'b1);
        chk("dut0_abort_busy", busy0, 1'b0);
        chk("dut0_abort_state", state0, 1'b0);
        chk("dut0_abort_valid", valid0, 1'b0);
        rst0 = 0;
        repeat (15) begin
            tick();
            chk("dut0_no_resume_notS", notS0, 1'b1);
            chk("dut0_no_resume_notR", notR0, 1'b1);
            chk("dut0_no_resume_busy", busy0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_latch_command_driver.md
Name: rs_latch_command_driver

Overview:
- Upstream stage for the basic active-low RS latch.
- Turns two raw, bouncy, asynchronous push-button inputs (set, reset) into clean, timed, active-low notS/notR pulses.
- Guarantees the latch never sees the forbidden notS=notR=0 input.
- Optionally clears the latch after reset, and tracks the expected latch state in a shadow register for downstream logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must hold a new level before the debounced level changes (>=1).
- PULSE_CYCLES, 3: cycles a notS/notR command pulse is held low (>=1).
- GAP_CYCLES, 2: cycles both outputs stay high after a pulse before the next pulse may start (>=0).
- INIT_CLEAR, 1: 1 = issue one notR pulse immediately after reset release; 0 = start in IDLE.
- CNT_W, 16: width of the internal timing counters. Must hold max(DEBOUNCE_CYCLES, PULSE_CYCLES, GAP_CYCLES).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- set_btn  in  1  raw set request, active-high, asynchronous, may bounce.
- reset_btn  in  1  raw reset request, active-high, asynchronous, may bounce.
- notS  out  1  active-low set to latch, registered.
- notR  out  1  active-low reset to latch, registered.
- busy  out  1  high while in INIT, PULSE_S, PULSE_R or GAP.
- state_q  out  1  expected latch Q after the last completed pulse.
- shadow_valid  out  1  state_q is meaningful (at least one pulse completed).

Behaviour:
- Reset (rst=1 at a clock edge), effective from the next edge:
  - notS=1, notR=1, busy=0, state_q=0, shadow_valid=0.
  - Synchronizers, debounced levels, counters and pending flags all cleared; FSM to RESET_HOLD.
  - rst asserted mid-pulse forces both outputs high at the next edge; no partial pulse resumes.
- Input path, per button:
  - 2-flop synchronizer, then debouncer.
  - The debounce counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - The debounced level toggles after DEBOUNCE_CYCLES consecutive differing cycles.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Events:
  - Only a 0->1 transition of a debounced level is an event; releases are not.
  - Each event sets a pending flag (set_pend / rst_pend).
  - Repeated events of the same kind while pending coalesce into one.
  - A held button yields exactly one event.
- FSM states:
  - RESET_HOLD: the cycle after rst deasserts, goes to INIT if INIT_CLEAR=1, else IDLE.
  - INIT: behaves as PULSE_R.
  - IDLE: if rst_pend, go to PULSE_R and clear rst_pend; else if set_pend, go to PULSE_S and clear set_pend; else stay. rst_pend has priority.
  - PULSE_S / PULSE_R: notS (resp. notR) = 0 for exactly PULSE_CYCLES cycles, the other output = 1. On the last pulse cycle, go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: both outputs 1 for GAP_CYCLES cycles, then IDLE.
- Shadow state: in the first cycle after any pulse ends, state_q = 1 after PULSE_S or 0 after PULSE_R, and shadow_valid = 1.
- Simultaneous events, or events while busy: latched as pending and serviced in priority order after GAP. Both pending gives the full reset pulse, gap, then the set pulse.
- Redundant commands (e.g. set while state_q=1) are still issued.
- Latency: from the first edge at which a raw press is stably high, with the FSM in IDLE and no pending events, notS/notR first reads 0 at edge 3+DEBOUNCE_CYCLES (default 7).
- Invariants, checked in all cases:
  - notS and notR are never both 0.
  - Every low pulse is exactly PULSE_CYCLES long.
  - Pulses are separated by at least GAP_CYCLES high cycles.

Test Plan:
- Reset, INIT_CLEAR=1: rst high 3 cycles then low -> outputs idle for one cycle, then notR=0 for 3 cycles, notS=1 throughout; busy=1 for 5 cycles; then state_q=0, shadow_valid=1.
- Clean set press held 20 cycles, FSM in IDLE -> notS low at edge 7 for exactly 3 cycles, then 2 gap cycles; state_q=1; only one pulse despite the hold.
- Bounce: set_btn toggles every cycle for 10 cycles, then settles low -> no pulse; notS stays 1, busy stays 0.
- Simultaneous press of both buttons -> notR pulse (3 cycles), 2-cycle gap, notS pulse (3 cycles); final state_q=1; notS&notR never both 0.
- Set pressed during a notR pulse, then pressed again during the gap -> exactly one notS pulse, starting the cycle after the gap ends.
- rst asserted on the 2nd cycle of a notS pulse -> notS=1 at the next edge; state_q=0, shadow_valid=0; no pulse resumes after release (INIT_CLEAR=0 build).
